// File: rtl/fifo_pop_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pop_serializer_pkg
// Shared serdes definitions used by the pop-side serializer and reused by the
// matching deserializer:
//   - WORD_CNT_W       : width of the completed-word counter
//   - serdes_state_e   : two-state link FSM encoding (IDLE / SEND)
//   - serdes_slice_pos : slice-select function driving the output mux; maps
//                        the running slice index onto a slice position inside
//                        the held word according to the byte order.
// -----------------------------------------------------------------------------
package fifo_pop_serializer_pkg;

    localparam int unsigned WORD_CNT_W = 32'd16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } serdes_state_e;

    // Position 0 is the least significant slice of the word. With
    // lsb_first=0 the slice index k walks the word from the top down.
    function automatic int unsigned serdes_slice_pos(
        input int unsigned k,
        input int unsigned ratio,
        input logic        lsb_first
    );
        int unsigned pos;
        if (lsb_first) begin
            pos = k;
        end else begin
            pos = ratio - 32'd1 - k;
        end
        return pos;
    endfunction

endpackage

// File: rtl/fifo_pop_serializer_if.sv
// -----------------------------------------------------------------------------
// fifo_pop_serializer_if
// Bundles the FIFO pop-side handshake and the link-side flit handshake.
//   fifo_empty_i, fifo_data_i       : FIFO pop port (data valid when not empty)
//   fifo_pop_req_n_o                : active-low pop request to the FIFO
//   link_valid_o/data_o/last_o      : flit toward the link
//   link_ready_i                    : link accepts the flit when valid
//   busy_o, word_cnt_o              : status
// modport master : the serializer side
// modport slave  : the environment (FIFO + link)
// -----------------------------------------------------------------------------
interface fifo_pop_serializer_if
    import fifo_pop_serializer_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
);
    logic                  fifo_empty_i;
    logic [IN_W-1:0]       fifo_data_i;
    logic                  fifo_pop_req_n_o;
    logic                  link_valid_o;
    logic [OUT_W-1:0]      link_data_o;
    logic                  link_last_o;
    logic                  link_ready_i;
    logic                  busy_o;
    logic [WORD_CNT_W-1:0] word_cnt_o;

    modport master (
        input  fifo_empty_i, fifo_data_i, link_ready_i,
        output fifo_pop_req_n_o, link_valid_o, link_data_o, link_last_o,
               busy_o, word_cnt_o
    );

    modport slave (
        output fifo_empty_i, fifo_data_i, link_ready_i,
        input  fifo_pop_req_n_o, link_valid_o, link_data_o, link_last_o,
               busy_o, word_cnt_o
    );
endinterface

// File: rtl/fifo_pop_serializer.sv
// -----------------------------------------------------------------------------
// fifo_pop_serializer
// Pops IN_W-bit words from the pop side of an asymmetric FIFO and sends each
// word as R = IN_W/OUT_W flits over a valid/ready link, one flit per cycle,
// with no bubble between consecutive words when the FIFO has data.
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high
//   sif   : fifo_pop_serializer_if.master (FIFO pop port, link port, status)
// Parameters: IN_W, OUT_W (IN_W multiple of OUT_W, R >= 2), BYTE_ORDER
//   (0 = most significant slice first, 1 = least significant slice first).
// -----------------------------------------------------------------------------
module fifo_pop_serializer
    import fifo_pop_serializer_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 8,
    parameter int BYTE_ORDER = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_pop_serializer_if.master sif
);

    localparam int R  = IN_W / OUT_W;
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    serdes_state_e         state_r;
    serdes_state_e         state_next_s;
    logic [IN_W-1:0]       shift_r;
    logic [CW-1:0]         slice_cnt_r;
    logic [CW-1:0]         slice_pos_s;
    logic [WORD_CNT_W-1:0] word_cnt_r;
    logic                  last_slice_s;
    logic                  pop_s;
    logic                  inc_s;
    logic                  done_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Control decode: pop, slice advance and word completion for this cycle.
    // A pop is gated by reset so a word is never taken out of the FIFO while
    // the block is being cleared.
    always_comb begin
        pop_s        = 1'b0;
        inc_s        = 1'b0;
        done_s       = 1'b0;
        last_slice_s = (slice_cnt_r == CW'(R - 1));
        case (state_r)
            ST_IDLE: begin
                pop_s = ~reset & ~sif.fifo_empty_i;
            end
            ST_SEND: begin
                if (sif.link_ready_i && last_slice_s) begin
                    done_s = 1'b1;
                    pop_s  = ~reset & ~sif.fifo_empty_i;
                end else begin
                    inc_s = sif.link_ready_i;
                end
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (done_s && !pop_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: word capture, slice counter and completed-word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r     <= '0;
            slice_cnt_r <= '0;
            word_cnt_r  <= '0;
        end else begin
            if (pop_s) begin
                shift_r     <= sif.fifo_data_i;
                slice_cnt_r <= '0;
            end else if (done_s) begin
                slice_cnt_r <= '0;
            end else if (inc_s) begin
                slice_cnt_r <= slice_cnt_r + CW'(1);
            end else begin
                slice_cnt_r <= slice_cnt_r;
            end
            if (done_s) begin
                word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
            end else begin
                word_cnt_r <= word_cnt_r;
            end
        end
    end

    // Slice-select for the output mux
    always_comb begin
        slice_pos_s = CW'(serdes_slice_pos(32'(slice_cnt_r), 32'(R), (BYTE_ORDER != 0)));
    end

    // Link and status outputs are decoded from registered state only; the
    // pop request is the one output that must react to fifo_empty_i in-cycle.
    assign sif.link_valid_o     = (state_r == ST_SEND);
    assign sif.link_last_o      = (state_r == ST_SEND) & last_slice_s;
    assign sif.link_data_o      = shift_r[slice_pos_s * OUT_W +: OUT_W];
    assign sif.busy_o           = (state_r == ST_SEND);
    assign sif.word_cnt_o       = word_cnt_r;
    assign sif.fifo_pop_req_n_o = ~pop_s;

endmodule

// File: tb/tb_fifo_pop_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_pop_serializer
// Drives two serializers (BYTE_ORDER 0 and 1) from one FIFO model and checks
// them every cycle against a flit-level reference: each popped word becomes
// four expected flits queued in send order; the link must present the queue
// head, a pop is expected exactly when the FIFO has data and the previous word
// is gone or its last flit is being accepted.
// -----------------------------------------------------------------------------
module tb_fifo_pop_serializer;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } flit_t;

    logic clk;
    logic reset;

    fifo_pop_serializer_if #(.IN_W(32), .OUT_W(8)) bus0 ();
    fifo_pop_serializer_if #(.IN_W(32), .OUT_W(8)) bus1 ();

    fifo_pop_serializer #(.IN_W(32), .OUT_W(8), .BYTE_ORDER(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .sif   (bus0)
    );

    fifo_pop_serializer #(.IN_W(32), .OUT_W(8), .BYTE_ORDER(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .sif   (bus1)
    );

    logic [31:0] fifo_q[$];
    flit_t       exp0_q[$];
    flit_t       exp1_q[$];
    logic [15:0] cnt_model;
    bit          chk_en;
    int          total;
    int          bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check at the falling edge, advance the
    // reference model after the rising edge.
    task automatic step(input bit rdy, input bit rst, input bit zero_chk);
        bit          exp_valid;
        bit          exp_pop;
        bit          acc;
        logic [31:0] w;
        flit_t       f;
        reset             = rst;
        bus0.link_ready_i = rdy;
        bus1.link_ready_i = rdy;
        bus0.fifo_empty_i = (fifo_q.size() == 0);
        bus1.fifo_empty_i = (fifo_q.size() == 0);
        w                 = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
        bus0.fifo_data_i  = w;
        bus1.fifo_data_i  = w;
        @(negedge clk);
        exp_valid = (exp0_q.size() != 0);
        exp_pop   = !rst && (fifo_q.size() != 0) && (!exp_valid || (rdy && exp0_q.size() == 1));
        if (chk_en) begin
            check_eq("pop_n0", 32'(bus0.fifo_pop_req_n_o), 32'(!exp_pop));
            check_eq("pop_n1", 32'(bus1.fifo_pop_req_n_o), 32'(!exp_pop));
            check_eq("valid0", 32'(bus0.link_valid_o), 32'(exp_valid));
            check_eq("valid1", 32'(bus1.link_valid_o), 32'(exp_valid));
            check_eq("busy0", 32'(bus0.busy_o), 32'(exp_valid));
            check_eq("busy1", 32'(bus1.busy_o), 32'(exp_valid));
            check_eq("wcnt0", 32'(bus0.word_cnt_o), 32'(cnt_model));
            check_eq("wcnt1", 32'(bus1.word_cnt_o), 32'(cnt_model));
            if (exp_valid) begin
                check_eq("data0", 32'(bus0.link_data_o), 32'(exp0_q[0].data));
                check_eq("data1", 32'(bus1.link_data_o), 32'(exp1_q[0].data));
                check_eq("last0", 32'(bus0.link_last_o), 32'(exp0_q[0].last));
                check_eq("last1", 32'(bus1.link_last_o), 32'(exp1_q[0].last));
            end else begin
                check_eq("last0_idle", 32'(bus0.link_last_o), 32'd0);
                check_eq("last1_idle", 32'(bus1.link_last_o), 32'd0);
            end
            if (zero_chk) begin
                check_eq("rst_data0", 32'(bus0.link_data_o), 32'd0);
                check_eq("rst_data1", 32'(bus1.link_data_o), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        acc = rdy && exp_valid;
        if (rst) begin
            exp0_q.delete();
            exp1_q.delete();
            cnt_model = 16'd0;
        end else begin
            if (acc) begin
                if (exp0_q[0].last) begin
                    cnt_model = cnt_model + 16'd1;
                end
                f = exp0_q.pop_front();
                f = exp1_q.pop_front();
            end
            if (exp_pop) begin
                w = fifo_q.pop_front();
                for (int j = 0; j < 4; j++) begin
                    f.data = 8'((w >> (8 * (3 - j))) & 32'hFF);
                    f.last = (j == 3);
                    exp0_q.push_back(f);
                    f.data = 8'((w >> (8 * j)) & 32'hFF);
                    exp1_q.push_back(f);
                end
            end
        end
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) begin
            step(rdy, 1'b0, 1'b0);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cnt_model = 16'd0;
        chk_en    = 1'b0;
        reset     = 1'b1;
        bus0.link_ready_i = 1'b0;
        bus1.link_ready_i = 1'b0;
        bus0.fifo_empty_i = 1'b1;
        bus1.fifo_empty_i = 1'b1;
        bus0.fifo_data_i  = 32'd0;
        bus1.fifo_data_i  = 32'd0;

        // Reset: outputs are defined once the first reset edge has passed
        step(1'b0, 1'b1, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        // Empty FIFO with the link ready: nothing happens
        run(20, 1'b1);

        // Single word, both byte orders checked side by side
        fifo_q.push_back(32'hA1B2C3D4);
        run(8, 1'b1);

        // Back-to-back words, no gap between them
        fifo_q.push_back(32'h11223344);
        fifo_q.push_back(32'h55667788);
        run(12, 1'b1);

        // Backpressure on the second slice
        fifo_q.push_back(32'hA1B2C3D4);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run(5, 1'b1);

        // Reset in the middle of a word
        fifo_q.push_back(32'hA1B2C3D4);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        fifo_q.push_back(32'h0F0F0F0F);
        run(7, 1'b1);

        // Completed-word counter wrap from a preloaded value
        force u_dut0.word_cnt_r = 16'hFFFE;
        force u_dut1.word_cnt_r = 16'hFFFE;
        cnt_model = 16'hFFFE;
        step(1'b1, 1'b0, 1'b0);
        release u_dut0.word_cnt_r;
        release u_dut1.word_cnt_r;
        fifo_q.push_back(32'hDEADBEEF);
        fifo_q.push_back(32'h01234567);
        fifo_q.push_back(32'h89ABCDEF);
        run(16, 1'b1);
        check_eq("wrap_cnt", 32'(bus0.word_cnt_o), 32'h0001);

        // Randomized traffic, link stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            bit rst_b;
            bit rdy_b;
            if (fifo_q.size() < 6 && ($urandom % 3) == 0) begin
                fifo_q.push_back($urandom);
            end
            rst_b = (($urandom % 300) == 0);
            rdy_b = rst_b ? 1'b0 : (($urandom % 10) < 7);
            step(rdy_b, rst_b, 1'b0);
        end

        // Drain whatever is left
        run(40, 1'b1);
        check_eq("drain_fifo", 32'(fifo_q.size()), 32'd0);
        check_eq("drain_flits", 32'(exp0_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
